sdram_port_sched: RTL and testbench

- Scheduler that shares the single SDRAM controller internal interface between PORTS wishbone-side port engines.
- Fixed priority: port 0 highest. Adds an age-based anti-starvation override and a MAX_BURST ack limit per grant.
- Sits between the per-port buffer engines and the SDRAM command sequencer, entirely in the sdram_clk domain.
- Port switches occur only while the controller reports idle.

---
 rtl/sdram_pkg.sv | 34 +++
 rtl/sched_age_cnt.sv | 40 ++++
 rtl/sdram_port_sched.sv | 137 +++++++++++++
 tb/tb_sdram_port_sched.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM port scheduler:
//   - sched_state_e : scheduler FSM state encoding (IDLE / GRANT / RELEASE)
//   - MAX_PORTS     : widest request vector the helper functions accept
//   - lowest_set    : isolates the lowest-index set bit of a vector
//   - onehot_to_idx : converts a one-hot vector into its bit index
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int MAX_PORTS = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } sched_state_e;

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [MAX_PORTS-1:0] lowest_set(input logic [MAX_PORTS-1:0] v);
        return v & (~v + MAX_PORTS'(1));
    endfunction

    // Returns 0 for an all-zero vector; callers only use the result when a bit is set.
    function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sched_age_cnt.sv
// -----------------------------------------------------------------------------
// sched_age_cnt
// Saturating wait-age counter for one requesting port. Counts cycles in which
// the port requests but is not granted; flags when the count hits AGE_LIMIT.
// Ports:
//   sdram_clk, sdram_rst_n : clock, asynchronous active-low reset
//   req                    : port access request
//   granted                : port currently owns the controller
//   expired                : age has reached AGE_LIMIT
// -----------------------------------------------------------------------------
module sched_age_cnt #(
    parameter int AGE_LIMIT = 64
) (
    input  logic sdram_clk,
    input  logic sdram_rst_n,
    input  logic req,
    input  logic granted,
    output logic expired
);

    localparam int AW = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] LIMIT = AW'(AGE_LIMIT);

    logic [AW-1:0] age;

    // NOTE: async reset in the sensitivity list and non-blocking (<=) updates for
    // every flop, so all registers sample the same pre-edge values.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            age <= '0;
        end else if (!req || granted) begin
            age <= '0;
        end else if (age != LIMIT) begin
            age <= age + AW'(1);
        end
    end

    assign expired = (age == LIMIT);

endmodule

// File: rtl/sdram_port_sched.sv
// -----------------------------------------------------------------------------
// sdram_port_sched
// Shares one SDRAM controller interface between PORTS port engines.
// Fixed priority (port 0 highest) with an age-based anti-starvation override
// and a MAX_BURST ack limit per grant when another port is waiting.
// Ports:
//   sdram_clk, sdram_rst_n          : clock, asynchronous active-low reset
//   p_acc_i/p_adr_i/p_dat_i/
//   p_sel_i/p_we_i                  : per-port request bundles (port i at slice i)
//   p_ack_o                         : controller ack routed to the granted port
//   sdram_idle_i, ack_i             : controller idle status and data ack
//   acc_o/adr_o/dat_o/sel_o/we_o    : request bundle of the granted port
//   grant_o                         : registered one-hot grant (0 = none)
//   stray_ack_o                     : pulse after an ack arrived outside GRANT
// -----------------------------------------------------------------------------
module sdram_port_sched
    import sdram_pkg::*;
#(
    parameter int PORTS     = 3,
    parameter int MAX_BURST = 8,
    parameter int AGE_LIMIT = 64
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst_n,
    input  logic [PORTS-1:0]      p_acc_i,
    input  logic [PORTS*32-1:0]   p_adr_i,
    input  logic [PORTS*16-1:0]   p_dat_i,
    input  logic [PORTS*2-1:0]    p_sel_i,
    input  logic [PORTS-1:0]      p_we_i,
    output logic [PORTS-1:0]      p_ack_o,
    input  logic                  sdram_idle_i,
    input  logic                  ack_i,
    output logic                  acc_o,
    output logic [31:0]           adr_o,
    output logic [15:0]           dat_o,
    output logic [1:0]            sel_o,
    output logic                  we_o,
    output logic [PORTS-1:0]      grant_o,
    output logic                  stray_ack_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    sched_state_e     state;
    logic [BW-1:0]    burst_cnt;
    logic [BW-1:0]    burst_next;
    logic [PORTS-1:0] expired;
    logic             own_req;
    logic             other_req;
    int               win_idx;

    for (genvar g = 0; g < PORTS; g++) begin : g_age
        sched_age_cnt #(.AGE_LIMIT(AGE_LIMIT)) u_age (
            .sdram_clk   (sdram_clk),
            .sdram_rst_n (sdram_rst_n),
            .req         (p_acc_i[g]),
            .granted     (grant_o[g]),
            .expired     (expired[g])
        );
    end

    assign own_req    = |(p_acc_i & grant_o);
    assign other_req  = |(p_acc_i & ~grant_o);
    assign burst_next = burst_cnt + BW'(ack_i);

    // Starved ports override fixed priority; among them the lowest index wins.
    always_comb begin
        if (|expired) win_idx = onehot_to_idx(lowest_set(MAX_PORTS'(expired)));
        else          win_idx = onehot_to_idx(lowest_set(MAX_PORTS'(p_acc_i)));
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state       <= ST_IDLE;
            grant_o     <= '0;
            burst_cnt   <= '0;
            stray_ack_o <= 1'b0;
        end else begin
            stray_ack_o <= ack_i && (state != ST_GRANT);
            case (state)
                ST_IDLE: begin
                    if ((|p_acc_i) && sdram_idle_i) begin
                        grant_o   <= PORTS'(1) << win_idx;
                        burst_cnt <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!own_req) begin
                        grant_o   <= '0;
                        burst_cnt <= burst_next;
                        state     <= ST_RELEASE;
                    end else if (burst_next == BURST_MAX) begin
                        // Counter wraps either way; the grant is only forced off
                        // when someone else is waiting.
                        burst_cnt <= '0;
                        if (other_req) begin
                            grant_o <= '0;
                            state   <= ST_RELEASE;
                        end
                    end else begin
                        burst_cnt <= burst_next;
                    end
                end
                ST_RELEASE: begin
                    if (sdram_idle_i) state <= ST_IDLE;
                end
                default: begin
                    grant_o <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        adr_o = '0;
        dat_o = '0;
        sel_o = '0;
        we_o  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_o[i]) begin
                adr_o = p_adr_i[32*i +: 32];
                dat_o = p_dat_i[16*i +: 16];
                sel_o = p_sel_i[2*i +: 2];
                we_o  = p_we_i[i];
            end
        end
    end

    assign acc_o   = own_req && (state == ST_GRANT);
    assign p_ack_o = grant_o & {PORTS{ack_i && (state == ST_GRANT)}};

endmodule

// File: tb/tb_sdram_port_sched.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_sched
// Randomised and directed stimulus for sdram_port_sched (PORTS=3, MAX_BURST=8,
// AGE_LIMIT=4). A reference model predicts observable events (acks, stray
// pulses, grant changes) into a queue; a monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_sdram_port_sched;

    localparam int PORTS     = 3;
    localparam int MAX_BURST = 8;
    localparam int AGE_LIMIT = 4;

    logic                sdram_clk = 1'b0;
    logic                sdram_rst_n = 1'b0;
    logic [PORTS-1:0]    p_acc_i = '0;
    logic [PORTS*32-1:0] p_adr_i = '0;
    logic [PORTS*16-1:0] p_dat_i = '0;
    logic [PORTS*2-1:0]  p_sel_i = '0;
    logic [PORTS-1:0]    p_we_i = '0;
    logic [PORTS-1:0]    p_ack_o;
    logic                sdram_idle_i = 1'b1;
    logic                ack_i = 1'b0;
    logic                acc_o;
    logic [31:0]         adr_o;
    logic [15:0]         dat_o;
    logic [1:0]          sel_o;
    logic                we_o;
    logic [PORTS-1:0]    grant_o;
    logic                stray_ack_o;

    sdram_port_sched #(.PORTS(PORTS), .MAX_BURST(MAX_BURST), .AGE_LIMIT(AGE_LIMIT)) dut (
        .sdram_clk    (sdram_clk),
        .sdram_rst_n  (sdram_rst_n),
        .p_acc_i      (p_acc_i),
        .p_adr_i      (p_adr_i),
        .p_dat_i      (p_dat_i),
        .p_sel_i      (p_sel_i),
        .p_we_i       (p_we_i),
        .p_ack_o      (p_ack_o),
        .sdram_idle_i (sdram_idle_i),
        .ack_i        (ack_i),
        .acc_o        (acc_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .sel_o        (sel_o),
        .we_o         (we_o),
        .grant_o      (grant_o),
        .stray_ack_o  (stray_ack_o)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct packed {
        logic [PORTS-1:0] grant;
        logic [PORTS-1:0] p_ack;
        logic             stray;
        logic             acc;
        logic [31:0]      adr;
        logic [15:0]      dat;
        logic [1:0]       sel;
        logic             we;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works with an owner index and a phase: waiting for arbitration, serving
    // the owner, or draining until the controller is idle again.
    typedef enum {M_WAIT, M_SERVE, M_DRAIN} mphase_e;
    mphase_e          m_phase = M_WAIT;
    int               m_owner = -1;
    int               m_burst = 0;
    int               m_age[PORTS];
    bit               m_stray = 0;
    logic [PORTS-1:0] m_last_grant = '0;

    always @(negedge sdram_clk) begin : model
        obs_t    e;
        bit      own, others;
        int      nxt_owner;
        mphase_e nxt_phase;
        if (!sdram_rst_n) begin
            m_phase = M_WAIT; m_owner = -1; m_burst = 0; m_stray = 0; m_last_grant = '0;
            for (int i = 0; i < PORTS; i++) m_age[i] = 0;
        end else begin
            e = '0;
            own = 0;
            others = 0;
            if (m_owner >= 0) begin
                e.grant = PORTS'(1 << m_owner);
                own     = p_acc_i[m_owner];
                e.adr   = p_adr_i[32*m_owner +: 32];
                e.dat   = p_dat_i[16*m_owner +: 16];
                e.sel   = p_sel_i[2*m_owner +: 2];
                e.we    = p_we_i[m_owner];
            end
            for (int i = 0; i < PORTS; i++) if (i != m_owner && p_acc_i[i]) others = 1;
            e.acc   = (m_phase == M_SERVE) && own;
            e.p_ack = (m_phase == M_SERVE && ack_i) ? e.grant : '0;
            e.stray = m_stray;
            if (e.p_ack != 0 || e.stray || e.grant != m_last_grant) exp_q.push_back(e);
            m_last_grant = e.grant;

            nxt_owner = m_owner;
            nxt_phase = m_phase;
            case (m_phase)
                M_WAIT: if (p_acc_i != 0 && sdram_idle_i) begin
                    nxt_owner = -1;
                    for (int i = PORTS - 1; i >= 0; i--) if (m_age[i] == AGE_LIMIT) nxt_owner = i;
                    if (nxt_owner < 0)
                        for (int i = PORTS - 1; i >= 0; i--) if (p_acc_i[i]) nxt_owner = i;
                    nxt_phase = M_SERVE;
                    m_burst = 0;
                end
                M_SERVE: begin
                    if (ack_i) m_burst++;
                    if (!own) begin
                        nxt_phase = M_DRAIN; nxt_owner = -1;
                    end else if (m_burst == MAX_BURST) begin
                        m_burst = 0;
                        if (others) begin nxt_phase = M_DRAIN; nxt_owner = -1; end
                    end
                end
                default: if (sdram_idle_i) nxt_phase = M_WAIT;
            endcase
            for (int i = 0; i < PORTS; i++) begin
                if (p_acc_i[i] && m_owner != i) m_age[i] = (m_age[i] < AGE_LIMIT) ? m_age[i] + 1 : AGE_LIMIT;
                else m_age[i] = 0;
            end
            m_stray = ack_i && (m_phase != M_SERVE);
            m_owner = nxt_owner;
            m_phase = nxt_phase;
        end
    end

    // ---------------- monitor ----------------
    logic [PORTS-1:0] mon_prev = '0;

    always @(negedge sdram_clk) begin : monitor
        obs_t a, e;
        #1;
        if (!sdram_rst_n) begin
            mon_prev = grant_o;
            exp_q.delete();
        end else begin
            a = {grant_o, p_ack_o, stray_ack_o, acc_o, adr_o, dat_o, sel_o, we_o};
            if (p_ack_o != 0 || stray_ack_o || grant_o != mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_event: got grant=%b p_ack=%b stray=%b, expected no event at %0t",
                             grant_o, p_ack_o, stray_ack_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", 64'(a.grant), 64'(e.grant));
                    check("p_ack", 64'(a.p_ack), 64'(e.p_ack));
                    check("stray", 64'(a.stray), 64'(e.stray));
                    check("acc",   64'(a.acc),   64'(e.acc));
                    check("bus",   64'({a.adr, a.dat, a.sel, a.we}), 64'({e.adr, e.dat, e.sel, e.we}));
                end
            end
            mon_prev = grant_o;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL missed_event: got grant=%b p_ack=%b stray=%b, expected grant=%b p_ack=%b stray=%b at %0t",
                         grant_o, p_ack_o, stray_ack_o, e.grant, e.p_ack, e.stray, $time);
                exp_q.delete();
            end
        end
    end

    // ---------------- port agents / stimulus ----------------
    int               rem[PORTS];
    bit               refill[PORTS];
    int               ack_count[PORTS];
    int               ack_pct = 100, idle_pct = 100, stray_pct = 0;
    bit               rand_req = 0;
    logic [PORTS-1:0] seq[$];
    logic [PORTS-1:0] last_g;

    function automatic logic [PORTS-1:0] seq_at(input int k);
        return (k < seq.size()) ? seq[k] : '1;
    endfunction

    task automatic new_scenario();
        seq.delete();
        last_g = grant_o;
        for (int i = 0; i < PORTS; i++) ack_count[i] = 0;
    endtask

    task automatic run(input int n);
        logic [PORTS-1:0] seen;
        for (int c = 0; c < n; c++) begin
            @(negedge sdram_clk);
            #2;
            seen = p_ack_o;
            for (int i = 0; i < PORTS; i++) if (seen[i]) ack_count[i]++;
            if (grant_o != last_g) begin
                seq.push_back(grant_o);
                last_g = grant_o;
            end
            @(posedge sdram_clk);
            #1;
            for (int i = 0; i < PORTS; i++) begin
                if (rem[i] == 0 && refill[i]) rem[i] = 1;
                else if (seen[i] && rem[i] > 0) rem[i]--;
                if (rand_req && rem[i] == 0 && $urandom_range(7) == 0) rem[i] = $urandom_range(12, 1);
                p_acc_i[i] = (rem[i] > 0);
                p_adr_i[32*i +: 32] = $urandom;
                p_dat_i[16*i +: 16] = 16'($urandom);
                p_sel_i[2*i +: 2]   = 2'($urandom);
                p_we_i[i]           = 1'($urandom);
            end
            sdram_idle_i = ($urandom_range(99) < idle_pct);
            #1;
            ack_i = acc_o ? ($urandom_range(99) < ack_pct) : ($urandom_range(99) < stray_pct);
        end
    endtask

    task automatic drain();
        rand_req = 0; ack_pct = 100; idle_pct = 100; stray_pct = 0;
        for (int i = 0; i < PORTS; i++) refill[i] = 0;
        run(40);
    endtask

    initial begin
        for (int i = 0; i < PORTS; i++) begin rem[i] = 0; refill[i] = 0; m_age[i] = 0; end

        // Reset state with busy inputs
        p_acc_i = '1; ack_i = 1'b1; p_adr_i = '1; p_dat_i = '1; p_sel_i = '1; p_we_i = '1;
        repeat (2) @(negedge sdram_clk);
        #1;
        check("rst_grant", 64'(grant_o), 64'(0));
        check("rst_acc_ack", 64'({acc_o, p_ack_o, stray_ack_o}), 64'(0));
        check("rst_bus", 64'({adr_o, dat_o, sel_o, we_o}), 64'(0));
        @(posedge sdram_clk);
        #1;
        p_acc_i = '0; ack_i = 1'b0; sdram_rst_n = 1'b1;
        run(3);

        // Single requester: port 1, 4 acks
        new_scenario();
        rem[1] = 4;
        run(15);
        check("single_seq0", 64'(seq_at(0)), 64'(3'b010));
        check("single_seq1", 64'(seq_at(1)), 64'(3'b000));
        check("single_acks", 64'(ack_count[1]), 64'(4));
        drain();

        // Simultaneous request: port 0 first, then aged ports in index order
        new_scenario();
        rem[0] = 3; rem[1] = 3; rem[2] = 3;
        run(40);
        check("simul_seq0", 64'(seq_at(0)), 64'(3'b001));
        check("simul_seq2", 64'(seq_at(2)), 64'(3'b010));
        check("simul_seq4", 64'(seq_at(4)), 64'(3'b100));
        drain();

        // Burst limit with contender
        new_scenario();
        rem[0] = 20; rem[2] = 2; idle_pct = 60;
        run(80);
        check("burst_seq0", 64'(seq_at(0)), 64'(3'b001));
        check("burst_seq1", 64'(seq_at(1)), 64'(3'b000));
        check("burst_seq2", 64'(seq_at(2)), 64'(3'b100));
        check("burst_acks0", 64'(ack_count[0]), 64'(20));
        check("burst_acks2", 64'(ack_count[2]), 64'(2));
        drain();

        // Burst limit, no contender: 20 acks under one grant
        new_scenario();
        rem[0] = 20;
        run(40);
        check("solo_seq_len", 64'(seq.size()), 64'(2));
        check("solo_seq0", 64'(seq_at(0)), 64'(3'b001));
        check("solo_acks", 64'(ack_count[0]), 64'(20));
        drain();

        // Starvation: port 0 re-requests after every transfer, port 1 waits
        new_scenario();
        rem[0] = 1; refill[0] = 1; rem[1] = 3;
        run(12);
        check("starve_seq0", 64'(seq_at(0)), 64'(3'b001));
        check("starve_seq2", 64'(seq_at(2)), 64'(3'b010));
        drain();

        // Stray ack in IDLE
        ack_i = 1'b1;
        @(posedge sdram_clk);
        #1;
        ack_i = 1'b0;
        @(negedge sdram_clk);
        #2;
        check("stray_pulse", 64'({stray_ack_o, p_ack_o}), 64'({1'b1, 3'b000}));
        @(negedge sdram_clk);
        #2;
        check("stray_clear", 64'(stray_ack_o), 64'(0));

        // Asynchronous reset in the middle of a grant
        new_scenario();
        rem[0] = 10;
        run(3);
        #1;
        check("arst_pre_grant", 64'(grant_o), 64'(3'b001));
        ack_i = 1'b1;
        sdram_rst_n = 1'b0;
        #1;
        check("arst_grant", 64'(grant_o), 64'(0));
        check("arst_acc_ack", 64'({acc_o, p_ack_o}), 64'(0));
        for (int i = 0; i < PORTS; i++) rem[i] = 0;
        p_acc_i = '0;
        repeat (2) @(negedge sdram_clk);
        @(posedge sdram_clk);
        #1;
        ack_i = 1'b0;
        sdram_rst_n = 1'b1;
        run(3);

        // Randomised traffic
        rand_req = 1; ack_pct = 60; idle_pct = 70; stray_pct = 5;
        run(3000);
        drain();

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
